bank_scan_reader: RTL and testbench

BANK_SCAN_READER -- requirements
Module: bank_scan_reader

---
 rtl/bank_scan_reader.sv | 157 +++++++++++++++
 tb/tb_bank_scan_reader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_scan_reader.sv
// ---------------------------------------------------------------------------
// bank_scan_reader
//
// Purpose:
//   Takes a snapshot of a four-entry bank and a four-bit entry-select mask
//   when a start request arrives. It then streams the selected entries out
//   over a valid/ready handshake in ascending index order, one entry per
//   accepted transfer. A one-cycle done pulse marks the end of each readout.
//   A start with an empty mask completes at once: done pulses and no data is
//   offered.
//
// Ports:
//   clk        in   1         single clock, rising-edge active
//   rst_n      in   1         asynchronous, active-low reset
//   start      in   1         readout request, sampled each rising edge
//   mask       in   4         entry select, bit i set -> entry i is read
//   bank_data  in   4*DATA_W  stored entries, entry i at [i*DATA_W +: DATA_W]
//   out_data   out  DATA_W    entry currently offered (0 when not valid)
//   out_sel    out  2         index of entry currently offered (0 when not valid)
//   out_valid  out  1         out_data/out_sel are valid
//   out_ready  in   1         consumer accepts the offered entry this cycle
//   busy       out  1         readout in progress
//   done       out  1         one-cycle pulse after a readout completes
// ---------------------------------------------------------------------------
module bank_scan_reader #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            mask,
  input  logic [4*DATA_W-1:0]   bank_data,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [1:0]          r_ptr;
  logic [1:0]          w_nextPtr;
  logic [3:0]          r_snapMask;
  logic [4*DATA_W-1:0] r_snapData;
  logic                r_done;
  logic                w_nextDone;

  logic                w_capture;
  logic                w_transfer;
  logic                w_lastEntry;
  logic [3:0]          w_higherBits;
  logic [1:0]          w_firstPtr;
  logic [1:0]          w_higherPtr;

  // Index of the lowest set bit. Callers only use the result when at least
  // one bit is set, so an all-zero input returning 0 is harmless.
  function automatic logic [1:0] lowestSet(input logic [3:0] bits);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bits[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // 4'b1110 << ptr keeps only the mask bits strictly above the current
  // pointer. That set being empty means the entry now offered is the last.
  assign w_capture    = (r_state == IDLE) && start && (mask != 4'd0);
  assign w_transfer   = (r_state == SEND) && out_ready;
  assign w_higherBits = r_snapMask & (4'b1110 << r_ptr);
  assign w_lastEntry  = (w_higherBits == 4'd0);
  assign w_firstPtr   = lowestSet(mask);
  assign w_higherPtr  = lowestSet(w_higherBits);

  // State, pointer, done and snapshot registers. The snapshot is written
  // only when a readout is accepted. Later changes on bank_data or mask
  // therefore never reach a readout that is already running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= 2'd0;
      r_done     <= 1'b0;
      r_snapMask <= 4'd0;
      r_snapData <= '0;
    end else begin
      r_state <= w_nextState;
      r_ptr   <= w_nextPtr;
      r_done  <= w_nextDone;
      if (w_capture) begin
        r_snapMask <= mask;
        r_snapData <= bank_data;
      end
    end
  end

  // Next-state logic. start is only looked at in IDLE, so it is ignored for
  // the whole of a readout. When the last entry transfers, the block goes
  // back to IDLE and raises done for the following cycle. An empty-mask
  // start also raises done, but the block stays in IDLE.
  always_comb begin
    w_nextState = r_state;
    w_nextPtr   = r_ptr;
    w_nextDone  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (mask != 4'd0) begin
            w_nextState = SEND;
            w_nextPtr   = w_firstPtr;
          end else begin
            w_nextDone = 1'b1;
          end
        end
      end
      SEND: begin
        if (w_transfer) begin
          if (w_lastEntry) begin
            w_nextState = IDLE;
            w_nextPtr   = 2'd0;
            w_nextDone  = 1'b1;
          end else begin
            w_nextPtr = w_higherPtr;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextPtr   = 2'd0;
      end
    endcase
  end

  // Output decode. Data and index are forced to zero whenever nothing is
  // offered. An asynchronous reset sends r_state to IDLE, so every output
  // drops immediately, without waiting for a clock edge.
  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    out_sel   = 2'd0;
    done      = r_done;
    if (r_state == SEND) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_data  = r_snapData[r_ptr*DATA_W +: DATA_W];
      out_sel   = r_ptr;
    end
  end

endmodule

// File: tb/tb_bank_scan_reader.sv
// ---------------------------------------------------------------------------
// tb_bank_scan_reader
//
// Drives bank_scan_reader with directed scenarios and a long randomized run.
// Every output is compared with a transaction-level model. At each accepted
// start, the model builds a queue of the expected (index, data) pairs. The
// queue head is the entry that should be on offer, and the model pops it
// whenever the consumer is ready. Directed scenarios add explicit
// constant-valued checks on top of the model.
// ---------------------------------------------------------------------------
module tb_bank_scan_reader;

  localparam int DATA_W = 8;

  typedef struct {
    logic [1:0]        sel;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [3:0]          mask;
  logic [4*DATA_W-1:0] bank_data;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_sel;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  logic                done;

  int checkCount;
  int errorCount;

  bit     mBusy;
  bit     mDone;
  entry_t mQueue[$];

  bank_scan_reader #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mask      (mask),
    .bank_data (bank_data),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advances the model by one rising edge, using the inputs present at that edge.
  task automatic modelEdge();
    if (mBusy) begin
      mDone = 1'b0;
      if (out_ready) begin
        void'(mQueue.pop_front());
        if (mQueue.size() == 0) begin
          mBusy = 1'b0;
          mDone = 1'b1;
        end
      end
    end else if (start) begin
      mDone = (mask == 4'd0);
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          entry_t e;
          e.sel  = 2'(i);
          e.data = bank_data[i*DATA_W +: DATA_W];
          mQueue.push_back(e);
        end
      end
      mBusy = (mQueue.size() != 0);
    end else begin
      mDone = 1'b0;
    end
  endtask

  task automatic compareModel();
    logic [1:0]        expSel;
    logic [DATA_W-1:0] expData;
    expSel  = 2'd0;
    expData = '0;
    if (mBusy) begin
      expSel  = mQueue[0].sel;
      expData = mQueue[0].data;
    end
    checkOutput("valid", 32'(out_valid), 32'(mBusy));
    checkOutput("busy",  32'(busy),      32'(mBusy));
    checkOutput("done",  32'(done),      32'(mDone));
    checkOutput("sel",   32'(out_sel),   32'(expSel));
    checkOutput("data",  32'(out_data),  32'(expData));
  endtask

  // One clock cycle: set the inputs, let the edge happen, then check on the falling edge.
  task automatic applyStimulus(input bit s, input logic [3:0] m,
                               input logic [4*DATA_W-1:0] b, input bit r);
    start     = s;
    mask      = m;
    bank_data = b;
    out_ready = r;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    compareModel();
  endtask

  task automatic resetModel();
    mBusy = 1'b0;
    mDone = 1'b0;
    mQueue.delete();
  endtask

  // Asserts reset mid-cycle and checks that the outputs drop before any edge.
  task automatic asyncReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rstValid", 32'(out_valid), 32'd0);
    checkOutput("rstBusy",  32'(busy),      32'd0);
    checkOutput("rstDone",  32'(done),      32'd0);
    checkOutput("rstSel",   32'(out_sel),   32'd0);
    checkOutput("rstData",  32'(out_data),  32'd0);
    resetModel();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    compareModel();
  endtask

  localparam logic [31:0] BANK = 32'h4433_2211;

  // Full four-entry scan with constant expectations for each cycle.
  task automatic fullScan();
    logic [DATA_W-1:0] expByte;
    applyStimulus(1'b1, 4'b1111, BANK, 1'b1);
    for (int i = 0; i < 4; i++) begin
      expByte = DATA_W'(8'h11 * (i + 1));
      checkOutput("scanSel",  32'(out_sel),  32'(i));
      checkOutput("scanData", 32'(out_data), 32'(expByte));
      checkOutput("scanBusy", 32'(busy),     32'd1);
      checkOutput("scanDone", 32'(done),     32'd0);
      applyStimulus(1'b0, 4'b0000, BANK, 1'b1);
    end
    checkOutput("scanEndDone",  32'(done),      32'd1);
    checkOutput("scanEndValid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 4'b0000, BANK, 1'b1);
    checkOutput("scanDoneOnce", 32'(done), 32'd0);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    resetModel();
    rst_n     = 1'b0;
    start     = 1'b0;
    mask      = 4'd0;
    bank_data = '0;
    out_ready = 1'b0;
    #2;
    checkOutput("initValid", 32'(out_valid), 32'd0);
    checkOutput("initBusy",  32'(busy),      32'd0);
    checkOutput("initDone",  32'(done),      32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 4'b0000, BANK, 1'b1);

    // Full scan.
    fullScan();

    // Sparse mask 1010.
    applyStimulus(1'b1, 4'b1010, BANK, 1'b1);
    checkOutput("sparseSel1",  32'(out_sel),  32'd1);
    checkOutput("sparseData1", 32'(out_data), 32'h22);
    applyStimulus(1'b0, 4'b0000, BANK, 1'b1);
    checkOutput("sparseSel2",  32'(out_sel),  32'd3);
    checkOutput("sparseData2", 32'(out_data), 32'h44);
    applyStimulus(1'b0, 4'b0000, BANK, 1'b1);
    checkOutput("sparseDone", 32'(done), 32'd1);
    applyStimulus(1'b0, 4'b0000, BANK, 1'b1);

    // Backpressure: ready low during cycles 1-3.
    applyStimulus(1'b1, 4'b1111, BANK, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'b0000, BANK, 1'b0);
      checkOutput("holdSel",  32'(out_sel),  32'd0);
      checkOutput("holdData", 32'(out_data), 32'h11);
    end
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b0, 4'b0000, BANK, 1'b1);
      checkOutput("bpSel", 32'(out_sel), 32'(i));
    end
    applyStimulus(1'b0, 4'b0000, BANK, 1'b1);
    checkOutput("bpDone", 32'(done), 32'd1);

    // Empty mask, immediately followed by a start in the done cycle.
    applyStimulus(1'b1, 4'b0000, BANK, 1'b1);
    checkOutput("emptyDone",  32'(done),      32'd1);
    checkOutput("emptyValid", 32'(out_valid), 32'd0);
    checkOutput("emptyBusy",  32'(busy),      32'd0);
    applyStimulus(1'b1, 4'b0100, BANK, 1'b1);
    checkOutput("b2bSel", 32'(out_sel), 32'd2);
    applyStimulus(1'b0, 4'b0000, BANK, 1'b1);
    checkOutput("b2bDone", 32'(done), 32'd1);
    applyStimulus(1'b0, 4'b0000, BANK, 1'b1);

    // Ignored inputs: start pulse and bank change in cycle 2.
    applyStimulus(1'b1, 4'b1111, BANK, 1'b1);
    applyStimulus(1'b1, 4'b1111, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(1'b0, 4'b0001, 32'hFFFF_FFFF, 1'b1);
    checkOutput("ignData", 32'(out_data), 32'h33);
    applyStimulus(1'b0, 4'b0000, 32'hFFFF_FFFF, 1'b1);
    checkOutput("ignData2", 32'(out_data), 32'h44);
    applyStimulus(1'b0, 4'b0000, BANK, 1'b1);
    checkOutput("ignDone", 32'(done), 32'd1);
    applyStimulus(1'b0, 4'b0000, BANK, 1'b1);
    checkOutput("ignNoSecond", 32'(busy), 32'd0);

    // Reset in the middle of a readout, then a full scan again.
    applyStimulus(1'b1, 4'b1111, BANK, 1'b1);
    applyStimulus(1'b0, 4'b0000, BANK, 1'b1);
    asyncReset();
    applyStimulus(1'b0, 4'b0000, BANK, 1'b1);
    checkOutput("rstNoDone", 32'(done), 32'd0);
    fullScan();

    // Randomized traffic, including resets now and then.
    for (int n = 0; n < 1500; n++) begin
      logic [3:0]          rm;
      logic [4*DATA_W-1:0] rb;
      bit                  rs;
      bit                  rr;
      rm = 4'($urandom_range(0, 15));
      rb = 32'($urandom);
      rs = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) asyncReset();
      else applyStimulus(rs, rm, rb, rr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
